// File: rtl/bank_sequencer_pkg.sv
// Shared definitions for the 6509 bank sequencer: opcodes tracked for
// indirect-indexed addressing, tracker state encoding, default bank value
// and the tracker next-state function.
package bank_sequencer_pkg;

    localparam logic [7:0] OP_LDA_IZY   = 8'hB1;
    localparam logic [7:0] OP_STA_IZY   = 8'h91;
    localparam logic [3:0] DEFAULT_BANK = 4'hF;

    // state | meaning
    // IDLE  | no indirect sequence in progress, ba follows exec_bank
    // ZP    | $B1/$91 fetched, next cycle reads the zero-page operand
    // PLO   | next cycle reads the pointer low byte
    // PHI   | next cycle reads the pointer high byte
    // IND   | operand data cycles (incl. page-cross dummy), ba = ind_bank
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ZP   = 3'd1,
        ST_PLO  = 3'd2,
        ST_PHI  = 3'd3,
        ST_IND  = 3'd4
    } state_t;

    function automatic logic is_ind_opcode(input logic [7:0] op);
        return (op == OP_LDA_IZY) || (op == OP_STA_IZY);
    endfunction

    // An opcode fetch overrides every other transition; otherwise the
    // sequence advances one step per completed bus cycle and parks in IND.
    function automatic state_t next_state(input state_t     cur,
                                          input logic       cyc_en,
                                          input logic       sync,
                                          input logic       rw,
                                          input logic [7:0] din);
        state_t nxt;
        nxt = cur;
        if (cyc_en) begin
            if (sync && rw) begin
                nxt = is_ind_opcode(din) ? ST_ZP : ST_IDLE;
            end else begin
                case (cur)
                    ST_IDLE: nxt = ST_IDLE;
                    ST_ZP:   nxt = ST_PLO;
                    ST_PLO:  nxt = ST_PHI;
                    ST_PHI:  nxt = ST_IND;
                    ST_IND:  nxt = ST_IND;
                    default: nxt = ST_IDLE;
                endcase
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bank_sequencer_if.sv
// CPU-side bus strobes into the bank sequencer and the bank/readback
// signals it returns to the pad logic.
interface bank_sequencer_if;
    import bank_sequencer_pkg::*;

    logic        cyc_en;
    logic        sync;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        phi2;

    logic [3:0]  ba;
    logic [3:0]  exec_bank;
    logic [3:0]  ind_bank;
    logic [7:0]  dout;
    logic        dout_oe;
    logic        ind_active;

    modport master (
        output cyc_en, sync, rw, addr, din, phi2,
        input  ba, exec_bank, ind_bank, dout, dout_oe, ind_active
    );

    modport slave (
        input  cyc_en, sync, rw, addr, din, phi2,
        output ba, exec_bank, ind_bank, dout, dout_oe, ind_active
    );

endinterface

// File: rtl/bank_sequencer_ind_tracker.sv
// Opcode tracker: follows LDA/STA (zp),Y through their operand fetches and
// reports whether the cycle after the current strobe is an indirect data
// cycle.
module ind_tracker
    import bank_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cyc_en,
    input  logic       sync,
    input  logic       rw,
    input  logic [7:0] din,
    output logic       ind_active_next
);

    state_t state;
    state_t state_nxt;

    assign state_nxt       = next_state(state, cyc_en, sync, rw, din);
    assign ind_active_next = (state_nxt == ST_IND);

    // Advance the sequence on each completed bus cycle; reset aborts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/bank_sequencer.sv
// Bank-address generator for the 6509 replacement core. Holds the
// execution ($0000) and indirection ($0001) bank registers and drives
// BA[3:0] with the indirection bank during (zp),Y operand data cycles.
// Optional macro BANK_READBACK_EN lets the CPU read both registers back.
module bank_sequencer
    import bank_sequencer_pkg::*;
#(
    parameter logic [3:0]  RESET_BANK = DEFAULT_BANK,
    parameter logic [15:0] EXEC_ADDR  = 16'h0000,
    parameter logic [15:0] IND_ADDR   = 16'h0001
) (
    input logic             clk,
    input logic             reset,
    bank_sequencer_if.slave bus
);

    logic [3:0] exec_q;
    logic [3:0] ind_q;
    logic [3:0] exec_nxt;
    logic [3:0] ind_nxt;
    logic [3:0] ba_q;
    logic       ind_active_q;
    logic       ind_active_nxt;
    logic       hit_exec;
    logic       hit_ind;

    assign hit_exec = (bus.addr == EXEC_ADDR);
    assign hit_ind  = (bus.addr == IND_ADDR);

    ind_tracker u_tracker (
        .clk             (clk),
        .reset           (reset),
        .cyc_en          (bus.cyc_en),
        .sync            (bus.sync),
        .rw              (bus.rw),
        .din             (bus.din),
        .ind_active_next (ind_active_nxt)
    );

    // Register writes snoop the CPU bus; memory still sees the write.
    always_comb begin
        exec_nxt = exec_q;
        ind_nxt  = ind_q;
        if (bus.cyc_en && !bus.rw) begin
            if (hit_exec) exec_nxt = bus.din[3:0];
            if (hit_ind)  ind_nxt  = bus.din[3:0];
        end
    end

    // Bank registers and the registered ba for the following cycle; ba uses
    // the post-write register values so a bank write takes effect at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_q       <= RESET_BANK;
            ind_q        <= RESET_BANK;
            ba_q         <= RESET_BANK;
            ind_active_q <= 1'b0;
        end else if (bus.cyc_en) begin
            exec_q       <= exec_nxt;
            ind_q        <= ind_nxt;
            ba_q         <= ind_active_nxt ? ind_nxt : exec_nxt;
            ind_active_q <= ind_active_nxt;
        end
    end

    assign bus.ba         = ba_q;
    assign bus.exec_bank  = exec_q;
    assign bus.ind_bank   = ind_q;
    assign bus.ind_active = ind_active_q;

`ifdef BANK_READBACK_EN
    // Readback drive follows phi2 directly, independent of the cycle strobe.
    always_comb begin
        bus.dout_oe = bus.phi2 && bus.rw && (hit_exec || hit_ind);
        bus.dout    = 8'h00;
        if (bus.dout_oe) begin
            bus.dout = hit_exec ? {4'h0, exec_q} : {4'h0, ind_q};
        end
    end
`else
    logic unused_readback;
    assign unused_readback = bus.phi2;
    assign bus.dout_oe     = 1'b0;
    assign bus.dout        = 8'h00;
`endif

endmodule
